// File: rtl/rv_fanout_pkg.sv
// ---- rv_fanout_pkg : shared defaults, token type and sizing helper for the fanout fork ----
// ---- Rev 1.0 ----
`default_nettype none

package rv_fanout_pkg;

  localparam int DATA_WIDTH = 17;
  localparam int NUM_OUT    = 7;
  localparam int DEPTH      = 2;

  typedef logic [DATA_WIDTH-1:0] token_t;

  // Bits needed to index n values, never less than 1.
  function automatic int unsigned clog2_depth(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

`default_nettype wire

// File: rtl/rv_fanout_fifo.sv
// ---- rv_fanout_fifo : ENTRIES-deep ring buffer, compare-based pointer wrap ----
// ---- Rev 1.0 ----
`default_nettype none

module rv_fanout_fifo
  import rv_fanout_pkg::*;
#(
  parameter int WIDTH   = DATA_WIDTH,
  parameter int ENTRIES = DEPTH
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             flush,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] wr_data,
  output logic [WIDTH-1:0] rd_data,
  output logic             empty,
  output logic             full
);

  localparam int PTR_W = int'(clog2_depth(ENTRIES));
  localparam int CNT_W = int'(clog2_depth(ENTRIES + 1));
  localparam logic [PTR_W-1:0] LAST = PTR_W'(ENTRIES - 1);
  localparam logic [CNT_W-1:0] CAP  = CNT_W'(ENTRIES);

  logic [WIDTH-1:0] mem [ENTRIES];
  logic [PTR_W-1:0] wr_ptr, rd_ptr;
  logic [CNT_W-1:0] count;
  logic             do_push, do_pop;

  function automatic logic [PTR_W-1:0] wrap_inc(input logic [PTR_W-1:0] p);
    return (p == LAST) ? '0 : p + 1'b1;
  endfunction

  assign empty   = (count == '0);
  assign full    = (count == CAP);
  assign do_push = push & ~full & ~flush;
  assign do_pop  = pop & ~empty & ~flush;
  assign rd_data = mem[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      for (int i = 0; i < ENTRIES; i++) mem[i] <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) begin
        mem[wr_ptr] <= wr_data;
        wr_ptr      <= wrap_inc(wr_ptr);
      end
      if (do_pop) rd_ptr <= wrap_inc(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

endmodule

`default_nettype wire

// File: rtl/rv_fanout_fork.sv
// ---- rv_fanout_fork : registered eager fork, one producer to NUM_OUT branches ----
// ---- Rev 1.0 ; optional stall counter via RV_FANOUT_STALL_CNT_EN ----
`default_nettype none

module rv_fanout_fork #(
  parameter int DATA_WIDTH = rv_fanout_pkg::DATA_WIDTH,
  parameter int NUM_OUT    = rv_fanout_pkg::NUM_OUT,
  parameter int DEPTH      = rv_fanout_pkg::DEPTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [NUM_OUT-1:0]    cfg_en,
  input  logic                  cfg_flush,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  output logic                  in_ready,
  output logic [DATA_WIDTH-1:0] out_data,
  output logic [NUM_OUT-1:0]    out_valid,
  input  logic [NUM_OUT-1:0]    out_ready
`ifdef RV_FANOUT_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  logic               empty, full;
  logic [NUM_OUT-1:0] sent, take;
  logic               all_done, head_pop;

  rv_fanout_fifo #(
    .WIDTH   (DATA_WIDTH),
    .ENTRIES (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .flush   (cfg_flush),
    .push    (in_valid),
    .pop     (head_pop),
    .wr_data (in_data),
    .rd_data (out_data),
    .empty   (empty),
    .full    (full)
  );

  // in_ready comes from the count register only, keeping out_ready off this path.
  assign in_ready  = ~full;
  assign out_valid = {NUM_OUT{~empty}} & cfg_en & ~sent;
  assign take      = out_valid & out_ready;
  assign all_done  = &(~cfg_en | sent | take);
  assign head_pop  = ~empty & all_done;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sent <= '0;
    end else if (cfg_flush || head_pop) begin
      sent <= '0;
    end else begin
      sent <= sent | take;
    end
  end

`ifdef RV_FANOUT_STALL_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles <= '0;
    end else if (cfg_flush) begin
      stall_cycles <= '0;
    end else if (~empty && ~all_done && (stall_cycles != 32'hFFFF_FFFF)) begin
      stall_cycles <= stall_cycles + 32'd1;
    end
  end
`endif

endmodule

`default_nettype wire

// File: tb/tb_rv_fanout_fork.sv
// ---- tb_rv_fanout_fork : randomized and directed checks against a queue-based model ----
// ---- Rev 1.0 ----
`default_nettype none

module tb_rv_fanout_fork;
  import rv_fanout_pkg::*;

  logic               clk;
  logic               rst_n;
  logic [NUM_OUT-1:0] cfg_en;
  logic               cfg_flush;
  token_t             in_data;
  logic               in_valid;
  logic               in_ready;
  token_t             out_data;
  logic [NUM_OUT-1:0] out_valid;
  logic [NUM_OUT-1:0] out_ready;
`ifdef RV_FANOUT_STALL_CNT_EN
  logic [31:0]        stall_cycles;
`endif

  rv_fanout_fork #(
    .DATA_WIDTH (DATA_WIDTH),
    .NUM_OUT    (NUM_OUT),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .cfg_en    (cfg_en),
    .cfg_flush (cfg_flush),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready)
`ifdef RV_FANOUT_STALL_CNT_EN
    ,
    .stall_cycles (stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: queue of pending tokens plus the set of branches that already took the head.
  token_t             q[$];
  logic [NUM_OUT-1:0] delivered;
  longint             stall_m;
  bit                 last_acc;
  int                 n_checks;
  int                 n_fail;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic compare_outputs();
    logic [NUM_OUT-1:0] ev;
    ev = (q.size() != 0) ? (cfg_en & ~delivered) : '0;
    check("in_ready", 64'(in_ready), 64'(q.size() < DEPTH));
    check("out_valid", 64'(out_valid), 64'(ev));
    if (q.size() != 0) check("out_data", 64'(out_data), 64'(q[0]));
`ifdef RV_FANOUT_STALL_CNT_EN
    check("stall_cycles", 64'(stall_cycles), 64'(stall_m));
`endif
  endtask

  // One clock cycle: check outputs, drive inputs, advance the model, cross the edge.
  task automatic step(input logic iv, input token_t d, input logic [NUM_OUT-1:0] rdy,
                      input logic fl);
    logic [NUM_OUT-1:0] took, done;
    bit accept;
    @(negedge clk);
    compare_outputs();
    in_valid  = iv;
    in_data   = d;
    out_ready = rdy;
    cfg_flush = fl;
    accept    = iv && (q.size() < DEPTH) && !fl;
    if (fl) begin
      q.delete();
      delivered = '0;
      stall_m   = 0;
    end else begin
      if (q.size() != 0) begin
        took = cfg_en & ~delivered & rdy;
        done = delivered | took | ~cfg_en;
        if (&done) begin
          void'(q.pop_front());
          delivered = '0;
        end else begin
          delivered = delivered | took;
          if (stall_m != 64'hFFFF_FFFF) stall_m++;
        end
      end
      if (accept) q.push_back(d);
    end
    last_acc = accept;
    @(posedge clk);
  endtask

  task automatic drain();
    for (int i = 0; i < 12 && q.size() != 0; i++) step(1'b0, '0, '1, 1'b0);
    if (q.size() != 0) check("drain_timeout", 64'(q.size()), 64'd0);
  endtask

  task automatic set_cfg(input logic [NUM_OUT-1:0] v);
    #1 cfg_en = v;
  endtask

  task automatic async_reset();
    @(negedge clk);
    in_valid  = 1'b0;
    cfg_flush = 1'b0;
    out_ready = '0;
    #2 rst_n = 1'b0;
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_out_data", 64'(out_data), 64'd0);
`ifdef RV_FANOUT_STALL_CNT_EN
    check("rst_stall", 64'(stall_cycles), 64'd0);
`endif
    q.delete();
    delivered = '0;
    stall_m   = 0;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    n_checks  = 0;
    n_fail    = 0;
    delivered = '0;
    stall_m   = 0;
    last_acc  = 0;
    rst_n     = 1'b0;
    cfg_en    = 7'h7F;
    cfg_flush = 1'b0;
    in_data   = '0;
    in_valid  = 1'b0;
    out_ready = '0;
    #12;
    check("reset_out_valid", 64'(out_valid), 64'd0);
    check("reset_in_ready", 64'(in_ready), 64'd1);
    check("reset_out_data", 64'(out_data), 64'd0);
`ifdef RV_FANOUT_STALL_CNT_EN
    check("reset_stall", 64'(stall_cycles), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;

    // Single token broadcast to all branches.
    step(1'b1, token_t'(17'h00A5), '1, 1'b0);
    #1 check("t1_valid", 64'(out_valid), 64'h7F);
    step(1'b0, '0, '1, 1'b0);
    step(1'b0, '0, '1, 1'b0);

    // Branch 0 takes early, branch 2 holds the head.
    set_cfg(7'b0000101);
    step(1'b1, token_t'(17'h1234), '0, 1'b0);
    step(1'b0, '0, 7'b0000001, 1'b0);
    #1 check("t2_valid", 64'(out_valid), 64'b0000100);
    step(1'b0, '0, 7'b0000001, 1'b0);
    step(1'b0, '0, 7'b0000001, 1'b0);
    step(1'b0, '0, 7'b0000101, 1'b0);
    drain();

    // Fill while stalled, then release; order checked via out_data.
    set_cfg(7'h7F);
    step(1'b1, token_t'(1), '0, 1'b0);
    step(1'b1, token_t'(2), '0, 1'b0);
    #1 check("t3_full", 64'(in_ready), 64'd0);
    step(1'b1, token_t'(3), '0, 1'b0);
    check("t3_reject", 64'(last_acc), 64'd0);
    for (int i = 0; i < 10; i++) begin
      step(1'b1, token_t'(3), '1, 1'b0);
      if (last_acc) break;
    end
    check("t3_third_taken", 64'(last_acc), 64'd1);
    drain();

    // Streaming at one token per cycle.
    for (int i = 0; i < 20; i++) begin
      step(1'b1, token_t'(100 + i), '1, 1'b0);
      check("t4_accept", 64'(last_acc), 64'd1);
    end
    drain();

    // No enabled branches: tokens are discarded.
    set_cfg('0);
    for (int i = 0; i < 4; i++) begin
      step(1'b1, token_t'(200 + i), NUM_OUT'($urandom), 1'b0);
      check("t5_accept", 64'(last_acc), 64'd1);
    end
    drain();

    // Flush with two tokens queued and a partial delivery.
    set_cfg(7'h7F);
    step(1'b1, token_t'(17'h0AAA), '0, 1'b0);
    step(1'b1, token_t'(17'h0BBB), '0, 1'b0);
    step(1'b0, '0, 7'b0000011, 1'b0);
    step(1'b0, '0, '0, 1'b1);
    #1 check("t6_flush_valid", 64'(out_valid), 64'd0);
    step(1'b0, '0, '0, 1'b0);

    // Same scenario, cleared by asynchronous reset.
    step(1'b1, token_t'(17'h0CCC), '0, 1'b0);
    step(1'b1, token_t'(17'h0DDD), '0, 1'b0);
    step(1'b0, '0, 7'b0000011, 1'b0);
    async_reset();
    step(1'b0, '0, '0, 1'b0);

    // Random traffic.
    for (int i = 0; i < 3000; i++) begin
      if (q.size() == 0 && ($urandom % 16) == 0) set_cfg(NUM_OUT'($urandom));
      step(($urandom % 4) != 0, token_t'($urandom), NUM_OUT'($urandom | $urandom),
           ($urandom % 40) == 0);
    end
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
